// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared line-state encoding, register offsets and helpers
package irq_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_ACKED = 2'd2
  } line_state_t;

  localparam logic [7:0] OFS_MASK = 8'd0;
  localparam logic [7:0] OFS_PEND = 8'd1;
  localparam logic [7:0] OFS_MISS = 8'd2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - source, CPU raise/ack and register bus signals of the controller
interface irq_controller_if #(
  parameter int N_IRQ = 2
);
  logic [N_IRQ-1:0] src_irq;
  logic [N_IRQ-1:0] irq_raise;
  logic [N_IRQ-1:0] irq_ack;
  logic [7:0]       bus_addr;
  logic [7:0]       bus_data_in;
  logic             bus_we;
  logic [7:0]       bus_data_out;
  logic             bus_data_oe;

  modport master (
    output src_irq, irq_ack, bus_addr, bus_data_in, bus_we,
    input  irq_raise, bus_data_out, bus_data_oe
  );

  modport slave (
    input  src_irq, irq_ack, bus_addr, bus_data_in, bus_we,
    output irq_raise, bus_data_out, bus_data_oe
  );
endinterface

// File: rtl/irq_controller_line.sv
// rtl/irq_controller_line.sv - one interrupt line: synchroniser, rise detect, pending,
// missed counter and raise/ack handshake FSM
module irq_controller_line
  import irq_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       src,
  input  logic       mask,
  input  logic       w1c,
  input  logic       clr_miss,
  input  logic       ack,
  output logic       raise,
  output logic       pending,
  output logic [7:0] missed
);

  logic        sync1, sync2, prev;
  logic        rise, clr, ack_clr;
  logic        pend_q, raise_q;
  logic [7:0]  miss_q;
  line_state_t state, state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  always_comb begin
    state_nx = state;
    ack_clr  = 1'b0;
    case (state)
      ST_IDLE:  if (pend_q && mask && !w1c) state_nx = ST_RAISE;
      ST_RAISE: begin
        if (ack) begin
          state_nx = ST_ACKED;
          ack_clr  = 1'b1;
        end else if (!mask || w1c) begin
          state_nx = ST_IDLE;
        end
      end
      // Holding off re-raise until ack is released avoids double-servicing one request.
      ST_ACKED: if (!ack) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign clr = ack_clr | w1c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      raise_q <= 1'b0;
      pend_q  <= 1'b0;
      miss_q  <= 8'd0;
    end else begin
      state   <= state_nx;
      raise_q <= (state_nx == ST_RAISE);
      // A new rise wins over a same-edge clear so the event is never dropped.
      pend_q  <= rise | (pend_q & ~clr);
      if (clr_miss) begin
        miss_q <= 8'd0;
      end else if (rise && pend_q && !clr) begin
        miss_q <= sat_inc(miss_q);
      end
    end
  end

  assign raise   = raise_q;
  assign pending = pend_q;
  assign missed  = miss_q;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - interrupt front-end: register decode, MASK register,
// registered read mux and one line instance per interrupt
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int         N_IRQ     = 2,
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input logic         clk,
  input logic         reset,
  irq_controller_if.slave bus
);

  logic [N_IRQ-1:0] mask_q, pending, raise, w1c, clr_miss;
  logic [7:0]       missed [N_IRQ];
  logic [8:0]       rel;
  logic [7:0]       ofs, rd_data, data_q;
  logic             hit, wr, oe_q;

  // Addresses below the base wrap to large 9-bit values and so never decode.
  assign rel = {1'b0, bus.bus_addr} - {1'b0, BASE_ADDR};
  assign hit = rel < (9'(OFS_MISS) + 9'(N_IRQ));
  assign ofs = rel[7:0];
  assign wr  = bus.bus_we & hit;

  always_comb begin
    w1c      = '0;
    clr_miss = '0;
    if (wr && ofs == OFS_PEND) w1c = bus.bus_data_in[N_IRQ-1:0];
    for (int i = 0; i < N_IRQ; i++) begin
      clr_miss[i] = wr && (ofs == OFS_MISS + 8'(i));
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (ofs == OFS_MASK) begin
      rd_data[N_IRQ-1:0] = mask_q;
    end else if (ofs == OFS_PEND) begin
      rd_data[N_IRQ-1:0] = pending;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (ofs == OFS_MISS + 8'(i)) rd_data = missed[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      data_q <= 8'h00;
      oe_q   <= 1'b0;
    end else begin
      if (wr && ofs == OFS_MASK) mask_q <= bus.bus_data_in[N_IRQ-1:0];
      oe_q   <= hit;
      data_q <= hit ? rd_data : 8'h00;
    end
  end

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_controller_line u_line (
      .clk      (clk),
      .reset    (reset),
      .src      (bus.src_irq[g]),
      .mask     (mask_q[g]),
      .w1c      (w1c[g]),
      .clr_miss (clr_miss[g]),
      .ack      (bus.irq_ack[g]),
      .raise    (raise[g]),
      .pending  (pending[g]),
      .missed   (missed[g])
    );
  end

  assign bus.irq_raise    = raise;
  assign bus.bus_data_out = data_q;
  assign bus.bus_data_oe  = oe_q;

endmodule
